cond_exec_unit: RTL

Parametrised conditional-execution unit for the ARMv4 core, the successor to the combinational condition checker. It holds the architectural NZCV flag register with split NZ/CV write enables, evaluates each instruction's condition against the registered flags, and sequences IT-style predicated blocks of up to `IT_MAX_LEN` instructions. It sits between decode and the register-file/memory write enables, and gates every architectural side effect.

---
 rtl/cond_exec_unit.sv | 101 ++++++++++
 1 files changed

// File: rtl/cond_exec_unit.sv
// cond_exec_unit: NZCV flag register, condition evaluation and IT-block sequencing; optional COND_SKIP_CNT_EN adds an annulled-instruction counter
module cond_exec_unit #(
  parameter int IT_MAX_LEN = 4,
  parameter int CNT_W = 16,
  localparam int RW = $clog2(IT_MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_i,
  input  logic [3:0]            cond_i,
  input  logic [1:0]            flag_w_i,
  input  logic [3:0]            alu_flags_i,
  input  logic                  it_start_i,
  input  logic [3:0]            it_cond_i,
  input  logic [RW-1:0]         it_len_i,
  input  logic [IT_MAX_LEN-1:0] it_then_i,
  input  logic                  flush_i,
  output logic                  cond_ex_o,
  output logic [3:0]            flags_o,
  output logic                  it_active_o,
  output logic [RW-1:0]         it_remaining_o,
  output logic                  it_err_o,
  output logic [CNT_W-1:0]      skip_cnt_o
);
  logic                  active;
  logic [IT_MAX_LEN-1:0] pat;
  logic [3:0]            base;
  logic [RW-1:0]         rem;
  logic [3:0]            flags;
  logic [3:0]            slot_cond;
  logic                  go;
  logic                  len_ok;

  function automatic logic eval(input logic [3:0] c, input logic [3:0] f);
    logic r;
    case (c[3:1])
      3'd0: r = f[2];
      3'd1: r = f[1];
      3'd2: r = f[3];
      3'd3: r = f[0];
      3'd4: r = f[1] & ~f[2];
      3'd5: r = f[3] == f[0];
      3'd6: r = ~f[2] & (f[3] == f[0]);
      default: r = 1'b1;
    endcase
    return (c[3:1] == 3'd7) ? ~c[0] : r ^ c[0];
  endfunction

  assign go        = valid_i & ~flush_i;
  assign slot_cond = pat[0] ? base : {base[3:1], ~base[0]};
  assign len_ok    = (it_len_i != '0) && (it_len_i <= RW'(IT_MAX_LEN));
  assign it_err_o  = go & it_start_i & (active | ~len_ok);
  assign cond_ex_o = go & ~(active & it_start_i) & eval(active ? slot_cond : cond_i, flags);

  assign flags_o        = flags;
  assign it_active_o    = active;
  assign it_remaining_o = rem;

  // Flag register: only executed instructions write, NZ and CV independently
  always_ff @(posedge clk or posedge reset) begin
    if (reset) flags <= '0;
    else if (cond_ex_o) begin
      flags[3:2] <= flag_w_i[1] ? alu_flags_i[3:2] : flags[3:2];
      flags[1:0] <= flag_w_i[0] ? alu_flags_i[1:0] : flags[1:0];
    end
  end

  // IT sequencer: open on a legal start, consume one slot per retired instruction, abort on flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active <= 1'b0;
      pat    <= '0;
      base   <= '0;
      rem    <= '0;
    end else if (flush_i) begin
      active <= 1'b0;
      rem    <= '0;
    end else if (valid_i && active) begin
      pat    <= pat >> 1;
      rem    <= rem - RW'(1);
      active <= rem != RW'(1);
    end else if (valid_i && it_start_i && len_ok) begin
      active <= 1'b1;
      pat    <= it_then_i | IT_MAX_LEN'(1);
      base   <= it_cond_i;
      rem    <= it_len_i;
    end
  end

`ifdef COND_SKIP_CNT_EN
  logic [CNT_W-1:0] skip_cnt;
  // Saturating count of retired but annulled instructions
  always_ff @(posedge clk or posedge reset) begin
    if (reset) skip_cnt <= '0;
    else if (go && !cond_ex_o && !(&skip_cnt)) skip_cnt <= skip_cnt + CNT_W'(1);
  end
  assign skip_cnt_o = skip_cnt;
`else
  assign skip_cnt_o = '0;
`endif
endmodule
